// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit that retires one bit per clock.
// The result goes back to the register file through the one-cycle wbEn/wbSel port.
module mul_div_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       dst,
  output logic             busy,
  output logic             done,
  output logic             wbEn,
  output logic [3:0]       wbSel,
  output logic [WIDTH-1:0] result,
  output logic             dz
);

  localparam int CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  stateT            state, stateNext;
  logic [CntW-1:0]  cnt;
  logic [1:0]       opReg;
  logic [WIDTH-1:0] bReg;
  logic [3:0]       dstReg;
  logic [WIDTH-1:0] hi;        // product high half / partial remainder
  logic [WIDTH-1:0] lo;        // product low half / dividend-quotient shifter
  logic [WIDTH-1:0] resultReg;
  logic [3:0]       wbSelReg;
  logic             dzReg;

  logic             accept;
  logic             lastStep;
  logic [WIDTH:0]   mulSum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] hiNext;
  logic [WIDTH-1:0] loNext;

  assign accept   = (state != RUN) && start;
  assign lastStep = (state == RUN) && (cnt == CntW'(WIDTH - 1));

  // The borrow bit of the trial subtract decides quotient bit. With b == 0 the
  // shifted remainder never reaches bit WIDTH before the last step, so every
  // quotient bit is 1 and the remainder ends up equal to a.
  always_comb begin
    mulSum  = {1'b0, hi} + (lo[0] ? {1'b0, bReg} : '0);
    shifted = {hi, lo[WIDTH-1]};
    trial   = shifted - {1'b0, bReg};
    fits    = ~trial[WIDTH];
    hiNext  = '0;
    loNext  = '0;
    if (opReg[1]) begin
      hiNext = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
      loNext = {lo[WIDTH-2:0], fits};
    end else begin
      hiNext = mulSum[WIDTH:1];
      loNext = {mulSum[0], lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    stateNext = start ? RUN : IDLE;
      RUN:     stateNext = lastStep ? DONE : RUN;
      DONE:    stateNext = start ? RUN : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
    wbEn = (state == DONE);
    dz   = (state == DONE) && dzReg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      opReg     <= '0;
      bReg      <= '0;
      dstReg    <= '0;
      hi        <= '0;
      lo        <= '0;
      resultReg <= '0;
      wbSelReg  <= '0;
      dzReg     <= 1'b0;
    end else if (accept) begin
      cnt    <= '0;
      opReg  <= op;
      bReg   <= b;
      dstReg <= dst;
      hi     <= '0;
      lo     <= a;
    end else if (state == RUN) begin
      cnt <= cnt + 1'b1;
      hi  <= hiNext;
      lo  <= loNext;
      if (lastStep) begin
        // op[0] picks the high register: MULH product high, REMU remainder.
        resultReg <= opReg[0] ? hiNext : loNext;
        wbSelReg  <= dstReg;
        dzReg     <= opReg[1] && (bReg == '0);
      end
    end
  end

  assign result = resultReg;
  assign wbSel  = wbSelReg;

endmodule
